io_port_bank: RTL

I/O-port responder for the MCS8 pipelined core. It sits on the CPU's IO bus and serves the core's input and output port accesses. Input ports 0–6 are synchronised external pins, and port 7 is a status register. Writes to port 8 feed a transmit FIFO that drains over a valid/ready stream. Ports 9–15 are latched parallel outputs.

---
 rtl/io_port_bank.sv | 120 ++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// io_port_bank: IO-bus responder for the MCS8 core.
// Ports 0-6 read synchronised PIN_I bytes and port 7 reads FIFO status.
// Writes to STREAM_PORT push into a transmit FIFO that drains over TX_*.
// Writes to ports 9-15 load the latched POUT_O bytes.
// Optional macro IO_PORT_READBACK_EN: reads of ports 8-15 return the
// FIFO head and the POUT_O bytes instead of 0x00.
module io_port_bank #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [4:0]  STREAM_PORT = 5'd8
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [4:0]  IO_ADDR_I,
  input  logic [7:0]  IO_DAT_I,
  input  logic        IO_WR_I,
  input  logic        IO_RD_I,
  output logic [7:0]  IO_DAT_O,
  output logic        IO_WAIT_O,
  input  logic [55:0] PIN_I,
  output logic [55:0] POUT_O,
  output logic [7:0]  TX_DAT_O,
  output logic        TX_VALID_O,
  input  logic        TX_READY_I
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [55:0]   pinSync1;
  logic [55:0]   pinSync2;
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [3:0]    count;
  logic          full;
  logic          empty;
  logic          streamSel;
  logic          push;
  logic          pop;
  logic [7:0]    statusByte;
  logic [7:0]    rdData;

  assign full       = (count == 4'(FIFO_DEPTH));
  assign empty      = (count == 4'd0);
  assign statusByte = {count, 2'b00, full, empty};
  assign streamSel  = IO_WR_I && (IO_ADDR_I == STREAM_PORT);

  // Stall depends only on the registered full flag so TX_READY_I never
  // reaches IO_WAIT_O; a same-cycle pop therefore delays the push by one.
  assign IO_WAIT_O  = streamSel && full;
  assign push       = streamSel && !full;
  assign pop        = !empty && TX_READY_I;

  assign TX_VALID_O = !empty;
  assign TX_DAT_O   = fifoMem[rdPtr];

  // Two-flop synchroniser on every input pin.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      pinSync1 <= '0;
      pinSync2 <= '0;
    end else begin
      pinSync1 <= PIN_I;
      pinSync2 <= pinSync1;
    end
  end

  // Read data selection from the current (pre-write) state.
  always_comb begin
    rdData = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      if (IO_ADDR_I == 5'(k)) rdData = pinSync2[8*k +: 8];
    end
    if (IO_ADDR_I == 5'd7) rdData = statusByte;
`ifdef IO_PORT_READBACK_EN
    if (IO_ADDR_I == STREAM_PORT && !empty) rdData = TX_DAT_O;
    for (int unsigned j = 0; j < 7; j++) begin
      if (IO_ADDR_I == 5'(9 + j)) rdData = POUT_O[8*j +: 8];
    end
`endif
  end

  // Registered read port: loads on a read strobe, holds otherwise.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      IO_DAT_O <= '0;
    end else if (IO_RD_I) begin
      IO_DAT_O <= rdData;
    end
  end

  // Latched parallel output bytes for ports 9-15.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      POUT_O <= '0;
    end else if (IO_WR_I) begin
      for (int unsigned j = 0; j < 7; j++) begin
        if (IO_ADDR_I == 5'(9 + j)) POUT_O[8*j +: 8] <= IO_DAT_I;
      end
    end
  end

  // Transmit FIFO storage, pointers and occupancy count.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifoMem[wrPtr] <= IO_DAT_I;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 4'd1;
      else if (pop && !push) count <= count - 4'd1;
    end
  end

endmodule
